// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - MSB-first serial pattern generator with shadow 0101/1010 detector; optional PRBS7 idle fill under SERIAL_PATTERN_GEN_PRBS_EN
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SERIAL_PATTERN_GEN_PRBS_EN
    input  logic             prbs_en,
`endif
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done,
    output logic             exp_match,
    output logic [7:0]       exp_count
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // Shadow detector states: A* track a 0101 prefix, B* track a 1010 prefix.
    typedef enum logic [2:0] {
        SH_S0,
        SH_A0,
        SH_A01,
        SH_A010,
        SH_B1,
        SH_B10,
        SH_B101
    } shadow_t;

    state_t           state_q, state_d;
    shadow_t          shadow_q, shadow_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       count_q, count_d;
    logic             done_q, done_d;

    logic             bit_tick;
    logic             prbs_active;
    logic             prbs_bit;

    assign bit_tick = (div_q == DIV_LAST);

`ifdef SERIAL_PATTERN_GEN_PRBS_EN
    logic [6:0] lfsr_q, lfsr_d;

    assign prbs_active = (state_q == ST_IDLE) && prbs_en;
    assign prbs_bit    = lfsr_q[6];

    // PRBS7 (x^7+x^6+1) advances once per emitted idle bit; state survives words.
    always_comb begin
        lfsr_d = lfsr_q;
        if (prbs_active && bit_tick) begin
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    // LFSR register, seeded to all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 7'h7F;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign prbs_active = 1'b0;
    assign prbs_bit    = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shadow_q <= SH_S0;
            shift_q  <= '0;
            idx_q    <= '0;
            div_q    <= '0;
            count_q  <= 8'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            div_q    <= div_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    // Next state: leave IDLE on an accepted load, return when the last bit period wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load_valid) state_d = ST_SHIFT;
            ST_SHIFT: if (bit_tick && (idx_q == IDX_LAST)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture, bit-period divider, bit index, match counter.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        div_d   = div_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    shift_d = load_data;
                    idx_d   = '0;
                    div_d   = '0;
                    count_d = 8'd0;
                end else if (prbs_active) begin
                    div_d = bit_tick ? '0 : div_q + 1'b1;
                end else begin
                    div_d = '0;
                end
            end
            ST_SHIFT: begin
                if (exp_match && (count_q != 8'hFF)) begin
                    count_d = count_q + 8'd1;
                end
                if (bit_tick) begin
                    div_d = '0;
                    if (idx_q == IDX_LAST) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Shadow detector steps once per emitted bit, using the bit on d_out.
    always_comb begin
        shadow_d = shadow_q;
        if (d_valid) begin
            case (shadow_q)
                SH_S0:   shadow_d = d_out ? SH_B1   : SH_A0;
                SH_A0:   shadow_d = d_out ? SH_A01  : SH_A0;
                SH_A01:  shadow_d = d_out ? SH_B1   : SH_A010;
                SH_A010: shadow_d = d_out ? SH_B101 : SH_A0;
                SH_B1:   shadow_d = d_out ? SH_B1   : SH_B10;
                SH_B10:  shadow_d = d_out ? SH_B101 : SH_A0;
                SH_B101: shadow_d = d_out ? SH_B1   : SH_A010;
                default: shadow_d = SH_S0;
            endcase
        end
    end

    // Outputs decoded from state, divider and shadow state.
    always_comb begin
        load_ready = (state_q == ST_IDLE);
        busy       = (state_q == ST_SHIFT);
        d_valid    = ((state_q == ST_SHIFT) || prbs_active) && (div_q == '0);
        if (state_q == ST_SHIFT) begin
            d_out = shift_q[WIDTH-1];
        end else begin
            d_out = prbs_active & prbs_bit;
        end
        exp_match = d_valid && (((shadow_q == SH_A010) && d_out) ||
                                ((shadow_q == SH_B101) && !d_out));
        done      = done_q;
        exp_count = count_q;
    end

endmodule
